mlp_cfg_sequencer: RTL and testbench
====================================

# mlp_cfg_sequencer

Control block for a generic parameterised MLP datapath whose weights and biases are inputs rather than constants. It loads the full weight/bias vector from a byte-serial configuration stream into a shadow register and commits it atomically. It then sequences inference: it accepts input samples over a valid/ready handshake, holds them stable for a programmable settle interval while the combinational network resolves, and returns the class index over a second valid/ready handshake.

## Interface
Parameters:
- `W_BITS`, 168, width of the packed weight vector.
- `B_BITS`, 84, width of the packed bias vector.
- `IN_BITS`, 16, width of the packed input sample.
- `OUT_BITS`, 2, width of the class index.
- `SETTLE`, 4, cycles the input is held before the result is sampled; legal range 1..255.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: configuration byte valid.
- `cfg_data` in 8: configuration byte.
- `cfg_ready` out 1: configuration byte accepted when high together with `cfg_valid`.
- `cfg_done` out 1: a parameter set has been committed.
- `cfg_err` out 1: last load failed checksum; low when `MLP_CFG_CHECKSUM_EN` is undefined.
- `in_valid` in 1: input sample valid.
- `in_data` in IN_BITS: input sample.
- `in_ready` out 1: sample accepted when high together with `in_valid`.
- `mlp_inp` out IN_BITS: drives the datapath input.
- `mlp_weights` out W_BITS: drives the datapath weights.
- `mlp_biases` out B_BITS: drives the datapath biases.
- `mlp_out` in OUT_BITS: datapath class index.
- `res_valid` out 1: result valid.
- `res_data` out OUT_BITS: registered class index.
- `res_ready` in 1: result consumed.
- `busy` out 1: state is LOAD, EVAL or RESP.

## Operation
- Configuration stream:
  - `NBYTES = ceil((W_BITS+B_BITS)/8)`, which is 32 at the defaults.
  - Bytes are concatenated LSB-first into `{biases, weights}`: byte k fills bits [8k+7:8k], with weights occupying the low bits.
  - Pad bits above `W_BITS+B_BITS` in the last byte are ignored.
- States:
  - UNCFG (reset state): `cfg_ready`=1, `in_ready`=0.
  - LOAD: `cfg_ready`=1, `in_ready`=0. A byte counter counts bytes written to the shadow register.
  - IDLE: `cfg_ready`=1, `in_ready`=1.
  - EVAL: a settle counter runs.
  - RESP: `res_valid`=1.
- UNCFG or IDLE → LOAD: on the first accepted configuration byte, which is already written to shadow byte 0.
- LOAD → commit: when the final byte is accepted, the shadow register is copied into `mlp_weights`/`mlp_biases` on the next edge, `cfg_done` is set, and the state goes to IDLE.
- Committed parameters never change except at a commit. Partial loads are never visible on the datapath outputs.
- IDLE → EVAL: on an `in_valid && in_ready` edge, `in_data` is registered into `mlp_inp` and the settle counter is loaded with `SETTLE`.
- EVAL: the counter decrements each cycle. On the edge where it reaches 0, `mlp_out` is registered into `res_data` and the state goes to RESP.
- RESP → IDLE: on a `res_valid && res_ready` edge. `mlp_inp` holds its value until the next accepted sample.
- Simultaneous `cfg_valid` and `in_valid` in IDLE: the configuration byte wins; the sample is not accepted.
- `cfg_valid` in EVAL or RESP is ignored (`cfg_ready`=0).
- Reset mid-operation returns to UNCFG: `cfg_done`=0, parameter registers cleared, and any partial load is discarded.

## Timing
- Reset values:
  - `cfg_ready`=1.
  - `cfg_done`=0, `cfg_err`=0, `in_ready`=0, `res_valid`=0, `busy`=0.
  - `mlp_inp`, `mlp_weights`, `mlp_biases` and `res_data` all zero.
- Commit: the final byte is accepted at edge t. `mlp_weights`/`mlp_biases` are updated at edge t+1, with `cfg_done`=1 and `in_ready`=1 after t+1.
- Sample latency: a sample is accepted at edge t0. `mlp_inp` changes at t0 and `mlp_out` is sampled at edge t0+SETTLE. `res_valid` is high from t0+SETTLE.
- With `res_ready` held high, the handshake completes at t0+SETTLE+1 and the next sample can be accepted at t0+SETTLE+2. Peak throughput is one sample per SETTLE+2 cycles.
- All outputs are registered or are decodes of the state register; there is no combinational input→output path.

## Configuration
- `MLP_CFG_CHECKSUM_EN` defined:
  - `NBYTES+1` bytes are expected; the extra final byte equals the XOR of all preceding bytes.
  - On mismatch there is no commit, and `cfg_err` is set until the next LOAD entry, which clears it.
  - After a mismatch the state returns to IDLE if `cfg_done`=1, otherwise to UNCFG.
  - On match, the commit proceeds as normal and `cfg_err`=0.
- `MLP_CFG_CHECKSUM_EN` undefined:
  - Exactly `NBYTES` bytes are expected, with no checksum byte.
  - `cfg_err` is tied to 0.

## Test plan
- Reset then load bytes 0x00..0x1F back-to-back (valid held high) → the 32 bytes occupy edges 1..32; `cfg_done` rises one edge later (edge 33). Expect `mlp_weights[7:0]`=0x00, `mlp_weights[167:160]`=0x14, `mlp_biases[7:0]`=0x15, `mlp_biases[83:80]`=0xF.
- With `SETTLE`=4, configured, and a stub driving `mlp_out`=2'b10: accept `in_data`=16'h1234 at t0 → `mlp_inp`=16'h1234 and `res_valid` rises at t0+4 with `res_data`=2'b10. With `res_ready` low for 3 cycles, `res_valid` and `res_data` hold and `in_ready`=0.
- Load set A, then start loading set B and assert `rst` after 10 bytes → `cfg_done`=0, all parameter outputs 0, state UNCFG.
- In IDLE with set A committed, load set B → `mlp_weights` keeps set A through byte 31 and shows set B exactly one edge after the last byte.
- Assert `cfg_valid` and `in_valid` together in IDLE → the byte is accepted, `in_ready` drops, and `mlp_inp` is unchanged.
- With `MLP_CFG_CHECKSUM_EN`: send 32 bytes plus a wrong checksum → `cfg_err`=1, parameters unchanged, state IDLE or UNCFG as above. Resend with the correct XOR → commit and `cfg_err`=0.

Source files
------------

// File: rtl/mlp_cfg_sequencer.sv
// mlp_cfg_sequencer
// Control block for a parameterised MLP datapath. Loads the packed
// {biases, weights} vector byte-serially (LSB first) into a shadow register,
// commits it atomically one edge after the final byte, then sequences
// inference: accept a sample, hold it for SETTLE cycles, register the class
// index and present it over a valid/ready handshake.
//
// Optional feature: define MLP_CFG_CHECKSUM_EN to expect one extra trailing
// byte equal to the XOR of all parameter bytes. A mismatching load is dropped
// and flagged on cfg_err until the next load starts.
module mlp_cfg_sequencer #(
   parameter int W_BITS   = 168,
   parameter int B_BITS   = 84,
   parameter int IN_BITS  = 16,
   parameter int OUT_BITS = 2,
   parameter int SETTLE   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   input  logic [7:0]          cfg_data,
   output logic                cfg_ready,
   output logic                cfg_done,
   output logic                cfg_err,
   input  logic                in_valid,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                in_ready,
   output logic [IN_BITS-1:0]  mlp_inp,
   output logic [W_BITS-1:0]   mlp_weights,
   output logic [B_BITS-1:0]   mlp_biases,
   input  logic [OUT_BITS-1:0] mlp_out,
   output logic                res_valid,
   output logic [OUT_BITS-1:0] res_data,
   input  logic                res_ready,
   output logic                busy
);

   localparam int PBITS  = W_BITS + B_BITS;
   localparam int NBYTES = (PBITS + 7) / 8;
`ifdef MLP_CFG_CHECKSUM_EN
   localparam int LAST_IDX = NBYTES;        // trailing checksum byte
`else
   localparam int LAST_IDX = NBYTES - 1;
`endif
   localparam int CW = $clog2(LAST_IDX + 2);

   localparam logic [2:0] S_UNCFG = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_IDLE  = 3'd2;
   localparam logic [2:0] S_EVAL  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   logic [2:0]       state;
   logic [CW-1:0]    byte_cnt;
   logic             commit_pend;
   logic [7:0]       settle_cnt;
   logic [PBITS-1:0] shadow;

   logic             cfg_acc;
   logic             in_acc;
   logic [CW-1:0]    byte_idx;
   logic             is_last;
   logic             shadow_wr;

`ifdef MLP_CFG_CHECKSUM_EN
   logic [7:0]       xor_acc;
   logic             err_q;
   assign cfg_err = err_q;
`else
   assign cfg_err = 1'b0;
`endif

   // Handshake outputs are pure decodes of registered state. The commit
   // cycle refuses bytes so the shadow is stable while it is copied.
   assign cfg_ready = (state == S_UNCFG) || (state == S_IDLE) ||
                      ((state == S_LOAD) && !commit_pend);
   assign in_ready  = (state == S_IDLE);
   assign res_valid = (state == S_RESP);
   assign busy      = (state == S_LOAD) || (state == S_EVAL) || (state == S_RESP);

   // A configuration byte takes priority over a sample offered in the same cycle.
   assign cfg_acc   = cfg_valid && cfg_ready;
   assign in_acc    = in_valid && in_ready && !cfg_valid;
   // The first byte of a load always lands in byte 0, whatever the stale count.
   assign byte_idx  = (state == S_LOAD) ? byte_cnt : '0;
   assign is_last   = (byte_idx == CW'(LAST_IDX));
   assign shadow_wr = cfg_acc && (byte_idx < CW'(NBYTES));

   // Shadow parameter register: byte k fills bits [8k+7:8k]; pad bits past PBITS are dropped.
   always_ff @(posedge clk) begin
      if (shadow_wr) begin
         for (int i = 0; i < PBITS; i++) begin
            if (byte_idx == CW'(i / 8)) shadow[i] <= cfg_data[3'(i % 8)];
         end
      end
   end

   // Sequencer: configuration load/commit, sample acceptance, settle timing, result handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_UNCFG;
         byte_cnt    <= '0;
         commit_pend <= 1'b0;
         settle_cnt  <= '0;
         cfg_done    <= 1'b0;
         mlp_weights <= '0;
         mlp_biases  <= '0;
         mlp_inp     <= '0;
         res_data    <= '0;
`ifdef MLP_CFG_CHECKSUM_EN
         xor_acc     <= '0;
         err_q       <= 1'b0;
`endif
      end else if (cfg_acc) begin
`ifdef MLP_CFG_CHECKSUM_EN
         if (state != S_LOAD) err_q <= 1'b0;
         xor_acc <= (byte_idx == '0) ? cfg_data : (xor_acc ^ cfg_data);
`endif
         if (!is_last) begin
            state    <= S_LOAD;
            byte_cnt <= byte_idx + 1'b1;
         end
`ifdef MLP_CFG_CHECKSUM_EN
         else if (cfg_data == xor_acc) begin
            state       <= S_LOAD;
            commit_pend <= 1'b1;
         end else begin
            // Bad checksum: discard the load, keep whatever set was committed.
            err_q    <= 1'b1;
            byte_cnt <= '0;
            state    <= cfg_done ? S_IDLE : S_UNCFG;
         end
`else
         else begin
            state       <= S_LOAD;
            commit_pend <= 1'b1;
         end
`endif
      end else if (commit_pend) begin
         mlp_weights <= shadow[W_BITS-1:0];
         mlp_biases  <= shadow[PBITS-1:W_BITS];
         cfg_done    <= 1'b1;
         commit_pend <= 1'b0;
         byte_cnt    <= '0;
         state       <= S_IDLE;
      end else if (in_acc) begin
         mlp_inp    <= in_data;
         settle_cnt <= 8'(SETTLE);
         state      <= S_EVAL;
      end else if (state == S_EVAL) begin
         // Sample the network on the edge where the count reaches zero.
         if (settle_cnt <= 8'd1) begin
            res_data   <= mlp_out;
            settle_cnt <= '0;
            state      <= S_RESP;
         end else begin
            settle_cnt <= settle_cnt - 8'd1;
         end
      end else if ((state == S_RESP) && res_ready) begin
         state <= S_IDLE;
      end
   end

endmodule

// File: tb/tb_mlp_cfg_sequencer.sv
// Testbench for mlp_cfg_sequencer: table of inference vectors plus directed
// sequences for load/commit timing, reset during a load, simultaneous
// byte/sample offers and (when MLP_CFG_CHECKSUM_EN is defined) checksum errors.
module tb_mlp_cfg_sequencer;

   localparam int W  = 168;
   localparam int B  = 84;
   localparam int IB = 16;
   localparam int OB = 2;
   localparam int ST = 4;
   localparam int NB = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid, cfg_ready, cfg_done, cfg_err;
   logic [7:0]    cfg_data;
   logic          in_valid, in_ready;
   logic [IB-1:0] in_data, mlp_inp;
   logic [W-1:0]  mlp_weights;
   logic [B-1:0]  mlp_biases;
   logic [OB-1:0] mlp_out_drv, res_data;
   logic          res_valid, res_ready, busy;

   mlp_cfg_sequencer #(
      .W_BITS(W), .B_BITS(B), .IN_BITS(IB), .OUT_BITS(OB), .SETTLE(ST)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .cfg_done(cfg_done), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mlp_inp(mlp_inp), .mlp_weights(mlp_weights), .mlp_biases(mlp_biases),
      .mlp_out(mlp_out_drv),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] din;
      logic [1:0]  mout;
      int          hold;
      logic [1:0]  exp_res;
   } vec_t;

   vec_t         vecs[4];
   logic [255:0] set_a, set_b;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_range(input logic [255:0] s, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = s[8*i +: 8];
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   // Sends bytes first..NB-1 (plus checksum when enabled) and checks atomic commit.
   task automatic load_rest(input logic [255:0] s, input logic [255:0] prev, input int first);
      logic [7:0] x;
      send_range(s, first, NB - 2);
      chk("busy_in_load", busy, 1'b1);
      chk("w_hold_mid", mlp_weights, prev[W-1:0]);
      send_range(s, NB - 1, NB - 1);
`ifdef MLP_CFG_CHECKSUM_EN
      x = '0;
      for (int i = 0; i < NB; i++) x = x ^ s[8*i +: 8];
      cfg_valid = 1'b1;
      cfg_data  = x;
      tick();
      cfg_valid = 1'b0;
`endif
      chk("w_hold_last", mlp_weights, prev[W-1:0]);
      chk("b_hold_last", mlp_biases, prev[W+B-1:W]);
      tick();
      chk("w_commit", mlp_weights, s[W-1:0]);
      chk("b_commit", mlp_biases, s[W+B-1:W]);
      chk("done_commit", cfg_done, 1'b1);
      chk("in_ready_commit", in_ready, 1'b1);
      chk("busy_commit", busy, 1'b0);
      chk("err_commit", cfg_err, 1'b0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      chk($sformatf("v%0d_in_ready", idx), in_ready, 1'b1);
      mlp_out_drv = ~v.mout;
      in_data     = v.din;
      in_valid    = 1'b1;
      tick();                               // t0
      in_valid  = 1'b0;
      cfg_valid = 1'b1;                     // must be ignored while evaluating
      cfg_data  = 8'h55;
      chk($sformatf("v%0d_inp", idx), mlp_inp, v.din);
      chk($sformatf("v%0d_busy", idx), busy, 1'b1);
      chk($sformatf("v%0d_cfg_ready_eval", idx), cfg_ready, 1'b0);
      for (int c = 1; c < ST; c++) begin
         tick();
         chk($sformatf("v%0d_early_valid_%0d", idx, c), res_valid, 1'b0);
      end
      mlp_out_drv = v.mout;
      cfg_valid   = 1'b0;
      tick();                               // t0+SETTLE
      mlp_out_drv = ~v.mout;
      chk($sformatf("v%0d_res_valid", idx), res_valid, 1'b1);
      chk($sformatf("v%0d_res_data", idx), res_data, v.exp_res);
      for (int h = 0; h < v.hold; h++) begin
         res_ready = 1'b0;
         tick();
         chk($sformatf("v%0d_hold_valid", idx), res_valid, 1'b1);
         chk($sformatf("v%0d_hold_data", idx), res_data, v.exp_res);
         chk($sformatf("v%0d_hold_in_ready", idx), in_ready, 1'b0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk($sformatf("v%0d_valid_drop", idx), res_valid, 1'b0);
      chk($sformatf("v%0d_back_idle", idx), in_ready, 1'b1);
      chk($sformatf("v%0d_inp_hold", idx), mlp_inp, v.din);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NB; k++) begin
         set_a[8*k +: 8] = 8'(k);
         set_b[8*k +: 8] = 8'(8'hAA + 7 * k);
      end
      vecs[0] = '{16'h1234, 2'b10, 3, 2'b10};
      vecs[1] = '{16'hABCD, 2'b01, 0, 2'b01};
      vecs[2] = '{16'hFFFF, 2'b11, 1, 2'b11};
      vecs[3] = '{16'h0F0F, 2'b00, 2, 2'b00};

      rst = 1'b1; cfg_valid = 0; cfg_data = 0; in_valid = 0; in_data = 0;
      res_ready = 0; mlp_out_drv = 0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_cfg_ready", cfg_ready, 1'b1);
      chk("rst_cfg_done", cfg_done, 1'b0);
      chk("rst_cfg_err", cfg_err, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_weights", mlp_weights, '0);
      chk("rst_biases", mlp_biases, '0);
      chk("rst_inp", mlp_inp, '0);
      chk("rst_res_data", res_data, '0);

      // Sample offered before any configuration is refused.
      in_valid = 1'b1; in_data = 16'hBEEF;
      tick();
      in_valid = 1'b0;
      chk("uncfg_sample_busy", busy, 1'b0);
      chk("uncfg_sample_inp", mlp_inp, '0);

      // Set A, then spot-check the packing.
      load_rest(set_a, '0, 0);
      chk("a_w_lo", mlp_weights[7:0], 8'h00);
      chk("a_w_hi", mlp_weights[167:160], 8'h14);
      chk("a_b_lo", mlp_biases[7:0], 8'h15);
      chk("a_b_top", mlp_biases[83:80], 4'hF);

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // Byte and sample together in IDLE: byte wins and starts loading set B.
      cfg_valid = 1'b1; cfg_data = set_b[7:0];
      in_valid  = 1'b1; in_data  = 16'h5555;
      tick();
      in_valid = 1'b0;
      chk("sim_in_ready", in_ready, 1'b0);
      chk("sim_inp", mlp_inp, 16'h0F0F);
      chk("sim_busy", busy, 1'b1);
      chk("sim_res_valid", res_valid, 1'b0);
      load_rest(set_b, set_a, 1);

      // Reset after 10 bytes of a new load.
      send_range(set_a, 0, 9);
      #2 rst = 1'b1;
      #1;
      chk("mrst_done", cfg_done, 1'b0);
      chk("mrst_weights", mlp_weights, '0);
      chk("mrst_biases", mlp_biases, '0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_cfg_ready", cfg_ready, 1'b1);
      chk("mrst_in_ready", in_ready, 1'b0);
      chk("mrst_inp", mlp_inp, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      // The partial load is gone: a fresh full load starts at byte 0.
      load_rest(set_a, '0, 0);
      run_vec(vecs[1], 4);

`ifdef MLP_CFG_CHECKSUM_EN
      send_range(set_b, 0, NB - 1);
      begin
         logic [7:0] x;
         x = '0;
         for (int i = 0; i < NB; i++) x = x ^ set_b[8*i +: 8];
         cfg_valid = 1'b1;
         cfg_data  = ~x;
         tick();
         cfg_valid = 1'b0;
      end
      tick();
      chk("csum_err", cfg_err, 1'b1);
      chk("csum_w_keep", mlp_weights, set_a[W-1:0]);
      chk("csum_b_keep", mlp_biases, set_a[W+B-1:W]);
      chk("csum_idle", in_ready, 1'b1);
      chk("csum_done_keep", cfg_done, 1'b1);
      load_rest(set_b, set_a, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
